// File: rtl/hockey_pkg.sv
// Shared puck-game types: coordinate width, default grid size and the per-frame position snapshot.
package hockey_pkg;

  localparam int unsigned COORD_W    = 3;
  localparam int unsigned GRID_N_DEF = 5;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic   valid;
    coord_t x;
    coord_t y;
  } snap_t;

endpackage

// File: rtl/puck_display_scanner_if.sv
// Puck engine -> LED matrix scanner link: coordinate stream in, matrix drive and status out.
interface puck_display_scanner_if
  import hockey_pkg::*;
#(
  parameter int unsigned GRID_N = GRID_N_DEF
) ();

  coord_t            X_COORD;
  coord_t            Y_COORD;
  logic              COORD_VALID;
  logic [GRID_N-1:0] ROW_SEL;
  logic [GRID_N-1:0] COL_DATA;
  logic              FRAME_TICK;
  logic              BOUNCE_FLAG;
  logic              RANGE_ERR;

  modport master (
    output X_COORD, Y_COORD, COORD_VALID,
    input  ROW_SEL, COL_DATA, FRAME_TICK, BOUNCE_FLAG, RANGE_ERR
  );

  modport slave (
    input  X_COORD, Y_COORD, COORD_VALID,
    output ROW_SEL, COL_DATA, FRAME_TICK, BOUNCE_FLAG, RANGE_ERR
  );

endinterface

// File: rtl/puck_display_scanner_scan_timer.sv
// Row scan timing: clock divider, row counter, one-hot row select and frame-edge strobe.
module scan_timer #(
  parameter  int unsigned GRID_N   = 5,
  parameter  int unsigned SCAN_DIV = 4,
  localparam int unsigned ROW_W    = $clog2(GRID_N)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ROW_W-1:0]  row_nxt_c,
  output logic [GRID_N-1:0] row_sel,
  output logic              frame_tick,
  output logic              frame_edge_c
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DIV_W-1:0] div;
  logic [ROW_W-1:0] row;
  logic             adv_c;

  assign adv_c        = (div == DIV_W'(SCAN_DIV - 1));
  assign frame_edge_c = adv_c && (row == ROW_W'(GRID_N - 1));

  // Row the matrix will show after the coming edge; lets the top register COL_DATA in step.
  always_comb begin
    row_nxt_c = row;
    if (adv_c) begin
      row_nxt_c = (row == ROW_W'(GRID_N - 1)) ? '0 : row + ROW_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div        <= '0;
      row        <= '0;
      row_sel    <= GRID_N'(1);
      frame_tick <= 1'b0;
    end else begin
      div        <= adv_c ? '0 : div + DIV_W'(1);
      row        <= row_nxt_c;
      row_sel    <= GRID_N'(1) << row_nxt_c;
      frame_tick <= frame_edge_c;
    end
  end

endmodule

// File: rtl/puck_display_scanner.sv
// Puck LED matrix scanner: per-frame position snapshot, wall-bounce blink and sticky range error.
// Optional PUCK_TRAIL_EN also draws the previous frame's position.
module puck_display_scanner
  import hockey_pkg::*;
#(
  parameter int unsigned GRID_N       = GRID_N_DEF,
  parameter int unsigned SCAN_DIV     = 4,
  parameter int unsigned BLINK_FRAMES = 8
) (
  input logic                   clk,
  input logic                   rst,
  puck_display_scanner_if.slave bus
);

  localparam int unsigned ROW_W = $clog2(GRID_N);
  localparam int unsigned CNT_W = 8;

  logic [ROW_W-1:0]  row_nxt_c;
  logic              frame_edge_c;

  snap_t             snap;
  snap_t             snap_nxt_c;
  snap_t             in_c;
  logic              in_bad_c;
  logic              wall_c;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt_c;
  logic [GRID_N-1:0] col_nxt_c;
`ifdef PUCK_TRAIL_EN
  snap_t             prev;
  snap_t             prev_nxt_c;
`endif

  scan_timer #(
    .GRID_N   (GRID_N),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_timer (
    .clk          (clk),
    .rst          (rst),
    .row_nxt_c    (row_nxt_c),
    .row_sel      (bus.ROW_SEL),
    .frame_tick   (bus.FRAME_TICK),
    .frame_edge_c (frame_edge_c)
  );

  function automatic logic in_range(input coord_t c);
    return 32'(c) < GRID_N;
  endfunction

  function automatic logic on_wall(input coord_t c);
    return (c == '0) || (32'(c) == GRID_N - 1);
  endfunction

  function automatic logic [GRID_N-1:0] draw(input snap_t s, input logic [ROW_W-1:0] r);
    draw = '0;
    if (s.valid && (32'(s.y) == 32'(r))) begin
      draw = GRID_N'(1) << s.x;
    end
  endfunction

  // Frame-edge snapshot update and bounce-hold counter; everything else holds between edges.
  always_comb begin
    in_c.valid = bus.COORD_VALID && in_range(bus.X_COORD) && in_range(bus.Y_COORD);
    in_c.x     = bus.X_COORD;
    in_c.y     = bus.Y_COORD;
    in_bad_c   = bus.COORD_VALID && !(in_range(bus.X_COORD) && in_range(bus.Y_COORD));
    wall_c     = in_c.valid && snap.valid &&
                 ((in_c.x != snap.x) || (in_c.y != snap.y)) &&
                 (on_wall(in_c.x) || on_wall(in_c.y));
    snap_nxt_c = snap;
    cnt_nxt_c  = cnt;
`ifdef PUCK_TRAIL_EN
    prev_nxt_c = prev;
`endif
    if (frame_edge_c) begin
      snap_nxt_c = in_c;
`ifdef PUCK_TRAIL_EN
      prev_nxt_c = snap;
`endif
      if (wall_c) begin
        cnt_nxt_c = CNT_W'(BLINK_FRAMES);
      end else if (cnt != '0) begin
        cnt_nxt_c = cnt - CNT_W'(1);
      end
    end
    col_nxt_c = draw(snap_nxt_c, row_nxt_c);
`ifdef PUCK_TRAIL_EN
    col_nxt_c = col_nxt_c | draw(prev_nxt_c, row_nxt_c);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap            <= '0;
      cnt             <= '0;
      bus.COL_DATA    <= '0;
      bus.BOUNCE_FLAG <= 1'b0;
      bus.RANGE_ERR   <= 1'b0;
`ifdef PUCK_TRAIL_EN
      prev            <= '0;
`endif
    end else begin
      snap            <= snap_nxt_c;
      cnt             <= cnt_nxt_c;
      bus.COL_DATA    <= col_nxt_c;
      bus.BOUNCE_FLAG <= (cnt_nxt_c != '0);
      if (frame_edge_c && in_bad_c) begin
        bus.RANGE_ERR <= 1'b1;
      end
`ifdef PUCK_TRAIL_EN
      prev            <= prev_nxt_c;
`endif
    end
  end

endmodule

// File: tb/tb_puck_display_scanner.sv
// Bench for puck_display_scanner: directed frames plus per-cycle random stimulus against a frame-level model.
module tb_puck_display_scanner;
  import hockey_pkg::*;

  localparam int N     = 5;
  localparam int D     = 4;
  localparam int BF    = 8;
  localparam int FRAME = N * D;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  puck_display_scanner_if #(.GRID_N(N)) bus_if ();

  puck_display_scanner #(
    .GRID_N       (N),
    .SCAN_DIV     (D),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: edges since reset, current/previous shown position, frames of blink left, sticky error.
  int edges;
  int cur_v, cur_x, cur_y;
  int old_v, old_x, old_y;
  int hold;
  int err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_col();
    int r = (edges / D) % N;
    int c = 0;
    if (cur_v != 0 && cur_y == r) c = c | (1 << cur_x);
`ifdef PUCK_TRAIL_EN
    if (old_v != 0 && old_y == r) c = c | (1 << old_x);
`endif
    return c;
  endfunction

  task automatic model_reset();
    edges = 0;
    cur_v = 0; cur_x = 0; cur_y = 0;
    old_v = 0; old_x = 0; old_y = 0;
    hold  = 0;
    err   = 0;
  endtask

  task automatic model_edge();
    int x, y, v, ok, moved, wall;
    if (edges % FRAME == FRAME - 1) begin
      x  = int'(bus_if.X_COORD);
      y  = int'(bus_if.Y_COORD);
      v  = int'(bus_if.COORD_VALID);
      ok = (v != 0 && x < N && y < N) ? 1 : 0;
      if (v != 0 && ok == 0) err = 1;
      moved = (x != cur_x || y != cur_y) ? 1 : 0;
      wall  = (ok != 0 && cur_v != 0 && moved != 0 &&
               (x == 0 || x == N - 1 || y == 0 || y == N - 1)) ? 1 : 0;
      if (wall != 0) hold = BF;
      else if (hold > 0) hold = hold - 1;
      old_v = cur_v; old_x = cur_x; old_y = cur_y;
      cur_v = ok;    cur_x = x;     cur_y = y;
    end
    edges++;
  endtask

  task automatic check_all();
    check("row_sel",     32'(bus_if.ROW_SEL),     32'(1 << ((edges / D) % N)));
    check("col_data",    32'(bus_if.COL_DATA),    32'(exp_col()));
    check("frame_tick",  32'(bus_if.FRAME_TICK),  (edges > 0 && edges % FRAME == 0) ? 32'd1 : 32'd0);
    check("bounce_flag", 32'(bus_if.BOUNCE_FLAG), (hold != 0) ? 32'd1 : 32'd0);
    check("range_err",   32'(bus_if.RANGE_ERR),   32'(err));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input int x, input int y, input int v);
    bus_if.X_COORD     = coord_t'(x);
    bus_if.Y_COORD     = coord_t'(y);
    bus_if.COORD_VALID = (v != 0);
  endtask

  task automatic frame(input int x, input int y, input int v);
    drive(x, y, v);
    repeat (FRAME) step();
  endtask

  // Assert reset off-edge, confirm immediate effect, release just after the following edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_row_sel",  32'(bus_if.ROW_SEL),     32'd1);
    check("rst_col_data", 32'(bus_if.COL_DATA),    32'd0);
    check("rst_tick",     32'(bus_if.FRAME_TICK),  32'd0);
    check("rst_bounce",   32'(bus_if.BOUNCE_FLAG), 32'd0);
    check("rst_range",    32'(bus_if.RANGE_ERR),   32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drive_random();
    int x, y, v;
    if ($urandom % 2 == 0) begin
      x = ($urandom % 24 == 0) ? 5 + int'($urandom % 3) : int'($urandom % 5);
      y = ($urandom % 24 == 0) ? 5 + int'($urandom % 3) : int'($urandom % 5);
      v = ($urandom % 8 == 0) ? 0 : 1;
      drive(x, y, v);
    end
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 0);
    model_reset();
    #1;
    do_reset();

    frame(0, 0, 0);
    frame(2, 3, 1);
    frame(2, 3, 1);

    frame(5, 1, 1);
    frame(1, 1, 1);
    frame(1, 1, 1);
    repeat (7) step();
    do_reset();

    frame(3, 1, 1);
    frame(4, 2, 1);
    repeat (9) frame(4, 2, 1);
    frame(0, 0, 0);
    frame(0, 2, 1);
    frame(0, 2, 1);

    frame(2, 2, 1);
    frame(4, 2, 1);
    frame(3, 0, 1);
    repeat (9) frame(3, 0, 1);

    frame(1, 1, 1);
    frame(2, 2, 1);
    frame(2, 2, 1);

    repeat (60 * FRAME) begin
      if ($urandom % 250 == 0) begin
        do_reset();
      end else begin
        drive_random();
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/puck_display_scanner.md
Name: puck_display_scanner

Overview:
Consumer side of the puck coordinate interface. Takes the X_COORD/Y_COORD stream from the puck motion engine and drives a row-scanned GRID_N x GRID_N LED matrix. It snapshots coordinates once per frame, flags wall contacts for a fixed number of frames, and flags illegal coordinates. It sits between the puck engine and the board LED matrix pins.

Parameters:
GRID_N, 5, matrix dimension and legal coordinate range 0..GRID_N-1 (2..8)
SCAN_DIV, 4, clock cycles each row is held active (>=1)
BLINK_FRAMES, 8, frames BOUNCE_FLAG stays high after a wall contact (1..255)

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-high
X_COORD  input  3  puck column from motion engine
Y_COORD  input  3  puck row from motion engine
COORD_VALID  input  1  puck in play; coordinates meaningful
ROW_SEL  output  GRID_N  one-hot active row; bit r = row Y=r
COL_DATA  output  GRID_N  lit columns for active row; bit c = column X=c
FRAME_TICK  output  1  one-cycle pulse at each frame boundary
BOUNCE_FLAG  output  1  high while the wall-contact hold counter is nonzero
RANGE_ERR  output  1  sticky illegal-coordinate flag

Behaviour:
- Reset (async, immediate): div=0, row=0, ROW_SEL=one-hot bit0, COL_DATA=0, FRAME_TICK=0, BOUNCE_FLAG=0, RANGE_ERR=0. Current and previous snapshots are invalid. Bounce counter is 0.
- All outputs are decoded from registers only. There is no combinational path from input to output.
- Divider: div counts 0..SCAN_DIV-1 and wraps. Row advances when div==SCAN_DIV-1. Row wraps GRID_N-1 -> 0.
- Frame edge = the clock edge where div==SCAN_DIV-1 and row==GRID_N-1. At that edge:
  - FRAME_TICK=1 for the following cycle.
  - Inputs sampled that cycle are latched into the snapshot. The old snapshot moves to prev.
- Snapshot valid = COORD_VALID && X<GRID_N && Y<GRID_N.
- If COORD_VALID && (X>=GRID_N || Y>=GRID_N) at a frame edge: RANGE_ERR<=1, held until rst. That snapshot is invalid, so its frame is blank.
- Inputs between frame edges are ignored. Frame length = GRID_N*SCAN_DIV cycles. A position shows within at most two frames of being presented.
- COL_DATA: bit px set iff snapshot valid && py==row. Otherwise all zero.
- Wall contact is detected at a frame edge when all of these hold:
  - the new snapshot is valid and the previous snapshot is valid;
  - the position differs from the previous one;
  - the new X is in {0, GRID_N-1} or the new Y is in {0, GRID_N-1}.
- On wall contact the bounce counter loads BLINK_FRAMES. Otherwise it decrements at each frame edge if nonzero. Load wins over decrement. BOUNCE_FLAG = (counter != 0).
- The first valid snapshot after an invalid one never raises BOUNCE_FLAG (serve at X=0 is not a bounce).
- COORD_VALID dropping: the next snapshot is invalid, the display blanks, and the counter keeps decrementing.
- Reset mid-frame: outputs revert immediately and scanning restarts at row 0, div 0.

Optional Feature:
Macro PUCK_TRAIL_EN.
- Defined: COL_DATA additionally lights the prev snapshot position (bit prev_x when prev valid && prev_y==row), ORed with the current position.
- Undefined: only the current snapshot is drawn, and prev is used solely for bounce detection.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package hockey_pkg holds:
  - coord width constant (3);
  - coord_t typedef;
  - default GRID_N constant, shared with the puck engine;
  - snapshot struct {valid, x, y}.
- One sub-module, scan_timer: divider, row counter, one-hot ROW_SEL, frame-edge strobe; parameterised by GRID_N and SCAN_DIV.
- The top level holds the snapshot/prev registers, COL_DATA decode, bounce counter and RANGE_ERR.

Test Plan:
(All with GRID_N=5, SCAN_DIV=4, so a frame is 20 cycles.)
1. Assert rst mid-stream -> ROW_SEL=00001, COL_DATA=0, all flags 0 immediately. After release, ROW_SEL=00010 after 4 cycles and FRAME_TICK pulses every 20 cycles.
2. Hold X=2, Y=3, VALID=1 across a frame edge -> next frame: COL_DATA=00100 while ROW_SEL=01000, 00000 in every other row. No BOUNCE_FLAG.
3. Present X=5, Y=1, VALID=1 at a frame edge -> RANGE_ERR=1 and that frame is blank. Return to X=1 -> display resumes, RANGE_ERR stays 1 until rst.
4. Snapshots (3,1) then (4,2) -> BOUNCE_FLAG=1 for exactly 8 FRAME_TICKs. VALID=0 then (0,2) -> BOUNCE_FLAG stays 0.
5. Wall contacts on consecutive frames (4,2), (3,0) -> counter reloads to 8 at the second edge and the flag stays high 8 frames from there.
6. PUCK_TRAIL_EN defined, snapshots (1,1) then (2,2) -> row1 COL=00010, row2 COL=00100. Undefined build -> row1 COL=00000.
